// File: rtl/vending_controller.sv
// Coin-operated vending controller: accumulates 5/10/25-cent coins, vends one
// item at PRICE, and returns change or cancelled credit as a train of nickels.
module vending_controller #(
  parameter int PRICE = 75
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       COIN_VALID,
  input  logic [1:0] COIN,
  input  logic       CANCEL,
  output logic       DISPENSE,
  output logic       NICKEL_OUT,
  output logic       REJECT,
  output logic [6:0] CREDIT,
  output logic       BUSY
);

  localparam logic [6:0] PRICE7 = 7'(PRICE);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t     state, state_nxt;
  logic [6:0] credit_nxt;
  logic [6:0] coin_val;
  logic       coin_ok;
  logic       reject_nxt;

  always_comb begin
    coin_ok  = 1'b1;
    coin_val = 7'd0;
    case (COIN)
      2'b00:   coin_val = 7'd5;
      2'b01:   coin_val = 7'd10;
      2'b10:   coin_val = 7'd25;
      default: coin_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = CREDIT;
    reject_nxt = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        // CANCEL wins over any coin strobed in the same cycle
        if (CANCEL) begin
          reject_nxt = COIN_VALID;
          if (state == COLLECT) state_nxt = CHANGE;
        end else if (COIN_VALID) begin
          if (!coin_ok) begin
            reject_nxt = 1'b1;
          end else begin
            credit_nxt = CREDIT + coin_val;
            state_nxt  = (credit_nxt >= PRICE7) ? VEND : COLLECT;
          end
        end
      end
      VEND: begin
        reject_nxt = COIN_VALID;
        credit_nxt = CREDIT - PRICE7;
        state_nxt  = (credit_nxt != 7'd0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_nxt = COIN_VALID;
        credit_nxt = (CREDIT >= 7'd5) ? CREDIT - 7'd5 : 7'd0;
        state_nxt  = (CREDIT <= 7'd5) ? IDLE : CHANGE;
      end
      default: begin
        state_nxt  = IDLE;
        credit_nxt = 7'd0;
      end
    endcase
  end

  // Pulse outputs are registered from the next state so they line up with it
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      CREDIT     <= 7'd0;
      DISPENSE   <= 1'b0;
      NICKEL_OUT <= 1'b0;
      REJECT     <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_nxt;
      CREDIT     <= credit_nxt;
      DISPENSE   <= (state_nxt == VEND);
      NICKEL_OUT <= (state_nxt == CHANGE);
      REJECT     <= reject_nxt;
      BUSY       <= (state_nxt == VEND) || (state_nxt == CHANGE);
    end
  end

endmodule
